// File: rtl/ctrl_unit.sv
// Hardwired control sequencer for the CPU datapath: fetch T0-T2, execute T3-T7,
// opcode decode from IR, memory wait-state handshake with timeout, halt handling.
//
// state   | meaning
// RESET   | held by clear=0, all strobes low
// T0      | PC to MAR, PC+1 into Z
// T1      | Z to PC, memory read (wait state)
// T2      | MDR to IR
// T3..T7  | execute steps, contents depend on opcode
// HALT    | stopped, left only via clear
module ctrl_unit #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        mem_rdy,
   input  logic        stop,
   output logic        PCout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        Cout,
   output logic        BAout,
   output logic        Rout,
   output logic        MARin,
   output logic        Zin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        Rin,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic        ADD,
   output logic        SUB,
   output logic        AND,
   output logic        OR,
   output logic        SHR,
   output logic        SHL,
   output logic        ROR,
   output logic        ROL,
   output logic        NEG,
   output logic        NOT,
   output logic        Run,
   output logic        mem_err
);

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   localparam logic [3:0] LP_WAIT_MAX = 4'(WAIT_MAX);

   state_t     r_state;
   logic [3:0] r_wait_cnt;
   logic       r_mem_err;

   logic [4:0] w_op;
   logic       w_is_ld, w_is_ldi, w_is_st, w_is_mem, w_is_alu2, w_is_un, w_is_halt;
   logic       w_wait, w_end;
   logic [9:0] w_alu_hot;
   logic [9:0] w_alu;
   logic       w_unused;

   assign w_op      = IR[31:27];
   assign w_unused  = ^IR[26:0];
   assign w_is_ld   = (w_op == 5'd0);
   assign w_is_ldi  = (w_op == 5'd1);
   assign w_is_st   = (w_op == 5'd2);
   assign w_is_mem  = w_is_ld | w_is_ldi | w_is_st;
   assign w_is_alu2 = (w_op >= 5'd3) && (w_op <= 5'd10);
   assign w_is_un   = (w_op == 5'd14) || (w_op == 5'd15);
   assign w_is_halt = (w_op == 5'd27);

   // ALU select lines ordered ADD (bit 9) down to NOT (bit 0)
   always_comb begin
      w_alu_hot = '0;
      if (w_is_alu2)
         w_alu_hot = 10'b10_0000_0000 >> (w_op - 5'd3);
      else if (w_op == 5'd14)
         w_alu_hot = 10'b00_0000_0010;
      else if (w_op == 5'd15)
         w_alu_hot = 10'b00_0000_0001;
   end

   assign w_wait = (r_state == S_T1) ||
                   ((r_state == S_T6) && w_is_ld) ||
                   ((r_state == S_T7) && w_is_st);

   assign w_end  = ((r_state == S_T3) && !(w_is_mem || w_is_alu2 || w_is_un || w_is_halt)) ||
                   ((r_state == S_T4) && w_is_un) ||
                   ((r_state == S_T5) && (w_is_alu2 || w_is_ldi)) ||
                   ((r_state == S_T7) && w_is_ld) ||
                   ((r_state == S_T7) && w_is_st && mem_rdy);

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         r_state    <= S_RESET;
         r_wait_cnt <= '0;
         r_mem_err  <= 1'b0;
      end else begin
         r_wait_cnt <= '0;
         if (w_wait && !mem_rdy) begin
            if (r_wait_cnt == LP_WAIT_MAX) begin
               r_state   <= S_HALT;
               r_mem_err <= 1'b1;
            end else begin
               r_wait_cnt <= r_wait_cnt + 4'd1;
            end
         end else if (w_end) begin
            r_state <= stop ? S_HALT : S_T0;
         end else begin
            case (r_state)
               S_RESET: r_state <= S_T0;
               S_T0:    r_state <= S_T1;
               S_T1:    r_state <= S_T2;
               S_T2:    r_state <= S_T3;
               S_T3:    r_state <= w_is_halt ? S_HALT : S_T4;
               S_T4:    r_state <= S_T5;
               S_T5:    r_state <= S_T6;
               S_T6:    r_state <= S_T7;
               default: r_state <= r_state;
            endcase
         end
      end
   end

   // Strobes follow the current state combinationally: IR is only loaded on the
   // T2->T3 edge, so opcode-dependent steps cannot be pre-registered.
   always_comb begin
      PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout  = 1'b0; BAout = 1'b0;
      Rout  = 1'b0; MARin   = 1'b0; Zin    = 1'b0; PCin  = 1'b0; MDRin = 1'b0;
      IRin  = 1'b0; Yin     = 1'b0; Rin    = 1'b0; Gra   = 1'b0; Grb   = 1'b0;
      Grc   = 1'b0; IncPC   = 1'b0; Read   = 1'b0; Write = 1'b0;
      w_alu = '0;
      case (r_state)
         S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
         S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
         S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         S_T3: begin
            if (w_is_mem) begin
               Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
            end else if (w_is_alu2) begin
               Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
            end else if (w_is_un) begin
               Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; w_alu = w_alu_hot;
            end
         end
         S_T4: begin
            if (w_is_mem) begin
               Cout = 1'b1; Zin = 1'b1; w_alu = 10'b10_0000_0000;
            end else if (w_is_alu2) begin
               Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; w_alu = w_alu_hot;
            end else if (w_is_un) begin
               Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end
         end
         S_T5: begin
            if (w_is_alu2 || w_is_ldi) begin
               Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (w_is_ld || w_is_st) begin
               Zlowout = 1'b1; MARin = 1'b1;
            end
         end
         S_T6: begin
            if (w_is_ld) begin
               Read = 1'b1; MDRin = 1'b1;
            end else if (w_is_st) begin
               Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
            end
         end
         S_T7: begin
            if (w_is_ld) begin
               MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (w_is_st) begin
               Write = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign {ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT} = w_alu;
   assign Run     = (r_state != S_RESET) && (r_state != S_HALT);
   assign mem_err = r_mem_err;

endmodule

// File: tb/tb_ctrl_unit.sv
// Bench for ctrl_unit: directed scenarios plus randomized instruction streams,
// checked every cycle against a microprogram-queue model of the sequencer.
module tb_ctrl_unit;
   localparam int WAIT_MAX = 15;

   localparam logic [28:0] M_PCOUT   = 29'h1 << 0;
   localparam logic [28:0] M_ZLOW    = 29'h1 << 1;
   localparam logic [28:0] M_MDROUT  = 29'h1 << 2;
   localparam logic [28:0] M_COUT    = 29'h1 << 3;
   localparam logic [28:0] M_BAOUT   = 29'h1 << 4;
   localparam logic [28:0] M_ROUT    = 29'h1 << 5;
   localparam logic [28:0] M_MARIN   = 29'h1 << 6;
   localparam logic [28:0] M_ZIN     = 29'h1 << 7;
   localparam logic [28:0] M_PCIN    = 29'h1 << 8;
   localparam logic [28:0] M_MDRIN   = 29'h1 << 9;
   localparam logic [28:0] M_IRIN    = 29'h1 << 10;
   localparam logic [28:0] M_YIN     = 29'h1 << 11;
   localparam logic [28:0] M_RIN     = 29'h1 << 12;
   localparam logic [28:0] M_GRA     = 29'h1 << 13;
   localparam logic [28:0] M_GRB     = 29'h1 << 14;
   localparam logic [28:0] M_GRC     = 29'h1 << 15;
   localparam logic [28:0] M_INCPC   = 29'h1 << 16;
   localparam logic [28:0] M_READ    = 29'h1 << 17;
   localparam logic [28:0] M_WRITE   = 29'h1 << 18;
   localparam logic [28:0] M_ADD     = 29'h1 << 19;

   localparam logic [28:0] W_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
   localparam logic [28:0] W_T1 = M_ZLOW | M_PCIN | M_READ | M_MDRIN;
   localparam logic [28:0] W_T2 = M_MDROUT | M_IRIN;
   localparam logic [28:0] W_WB = M_ZLOW | M_GRA | M_RIN;

   logic        clk = 1'b0;
   logic        clear = 1'b1;
   logic [31:0] IR = '0;
   logic        mem_rdy = 1'b0;
   logic        stop = 1'b0;
   logic PCout, Zlowout, MDRout, Cout, BAout, Rout, MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
   logic Gra, Grb, Grc, IncPC, Read, Write;
   logic ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT, Run, mem_err;
   logic [28:0] dut_w;

   ctrl_unit #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .clear(clear), .IR(IR), .mem_rdy(mem_rdy), .stop(stop),
      .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .BAout(BAout),
      .Rout(Rout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
      .Yin(Yin), .Rin(Rin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC),
      .Read(Read), .Write(Write), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR),
      .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
      .Run(Run), .mem_err(mem_err)
   );

   assign dut_w = {NOT, NEG, ROL, ROR, SHL, SHR, OR, AND, SUB, ADD, Write, Read, IncPC,
                   Grc, Grb, Gra, Rin, Yin, IRin, MDRin, PCin, Zin, MARin, Rout, BAout,
                   Cout, MDRout, Zlowout, PCout};

   initial forever #5 clk = ~clk;

   // Model: a queue of remaining micro-steps for the current instruction.
   typedef struct packed {
      logic [28:0] w;
      logic [2:0]  t;
      logic        wt;
      logic        hlt;
   } step_t;

   step_t m_q[$];
   int    m_mode = 0;   // 0 reset, 1 running, 2 halted
   int    m_wcnt = 0;
   bit    m_err  = 0;
   int    n_checks = 0;
   int    n_fail   = 0;

   function automatic step_t mk(logic [28:0] w, logic [2:0] t, logic wt, logic hlt);
      step_t s;
      s.w = w; s.t = t; s.wt = wt; s.hlt = hlt;
      return s;
   endfunction

   task automatic push_fetch();
      m_q.push_back(mk(W_T0, 3'd0, 1'b0, 1'b0));
      m_q.push_back(mk(W_T1, 3'd1, 1'b1, 1'b0));
      m_q.push_back(mk(W_T2, 3'd2, 1'b0, 1'b0));
   endtask

   task automatic push_exec(input logic [4:0] op);
      logic [28:0] a;
      a = '0;
      if (op >= 5'd3 && op <= 5'd10) a = 29'h1 << (19 + int'(op) - 3);
      if (op == 5'd14) a = 29'h1 << 27;
      if (op == 5'd15) a = 29'h1 << 28;
      if (op <= 5'd2) begin
         m_q.push_back(mk(M_GRB | M_BAOUT | M_YIN, 3'd3, 1'b0, 1'b0));
         m_q.push_back(mk(M_COUT | M_ADD | M_ZIN, 3'd4, 1'b0, 1'b0));
         if (op == 5'd1) begin
            m_q.push_back(mk(W_WB, 3'd5, 1'b0, 1'b0));
         end else begin
            m_q.push_back(mk(M_ZLOW | M_MARIN, 3'd5, 1'b0, 1'b0));
            if (op == 5'd0) begin
               m_q.push_back(mk(M_READ | M_MDRIN, 3'd6, 1'b1, 1'b0));
               m_q.push_back(mk(M_MDROUT | M_GRA | M_RIN, 3'd7, 1'b0, 1'b0));
            end else begin
               m_q.push_back(mk(M_GRA | M_ROUT | M_MDRIN, 3'd6, 1'b0, 1'b0));
               m_q.push_back(mk(M_WRITE, 3'd7, 1'b1, 1'b0));
            end
         end
      end else if (op <= 5'd10) begin
         m_q.push_back(mk(M_GRB | M_ROUT | M_YIN, 3'd3, 1'b0, 1'b0));
         m_q.push_back(mk(M_GRC | M_ROUT | a | M_ZIN, 3'd4, 1'b0, 1'b0));
         m_q.push_back(mk(W_WB, 3'd5, 1'b0, 1'b0));
      end else if (op == 5'd14 || op == 5'd15) begin
         m_q.push_back(mk(M_GRB | M_ROUT | a | M_ZIN, 3'd3, 1'b0, 1'b0));
         m_q.push_back(mk(W_WB, 3'd4, 1'b0, 1'b0));
      end else begin
         m_q.push_back(mk('0, 3'd3, 1'b0, op == 5'd27));
      end
   endtask

   // Advance the model by one rising edge using the inputs now being driven.
   task automatic model_advance();
      step_t s;
      if (!clear) begin
         m_mode = 0; m_q.delete(); m_wcnt = 0; m_err = 0;
         return;
      end
      if (m_mode == 0) begin
         m_mode = 1; m_q.delete(); push_fetch();
      end else if (m_mode == 1) begin
         s = m_q[0];
         if (s.wt && !mem_rdy) begin
            if (m_wcnt == WAIT_MAX) begin
               m_mode = 2; m_q.delete(); m_err = 1;
            end else begin
               m_wcnt++;
            end
         end else begin
            m_wcnt = 0;
            void'(m_q.pop_front());
            if (s.t == 3'd2) push_exec(IR[31:27]);
            if (s.hlt) begin
               m_mode = 2; m_q.delete();
            end else if (m_q.size() == 0) begin
               if (stop) m_mode = 2;
               else push_fetch();
            end
         end
      end
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic compare_all();
      logic [28:0] ew;
      ew = (m_mode == 1) ? m_q[0].w : '0;
      check("ctrl", {3'b0, dut_w}, {3'b0, ew});
      check("Run", {31'b0, Run}, {31'b0, m_mode == 1});
      check("mem_err", {31'b0, mem_err}, {31'b0, m_err});
   endtask

   task automatic tick();
      model_advance();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   function automatic logic [31:0] pick_ir();
      logic [4:0] tbl [14];
      logic [4:0] op;
      int k;
      tbl = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
              5'd14, 5'd15, 5'd27};
      k = $urandom_range(0, 15);
      op = (k < 14) ? tbl[k] : 5'($urandom);
      return {op, 27'($urandom)};
   endfunction

   initial begin
      int stall;
      #1 clear = 1'b0;
      repeat (2) @(negedge clk);
      compare_all();
      check("rst_ctrl", {3'b0, dut_w}, 32'h0);
      check("rst_run", {31'b0, Run}, 32'h0);

      // ld R1,0x85(R0) with memory always ready
      clear = 1'b1; IR = 32'h00800085; mem_rdy = 1'b1;
      tick(); check("ld_T0", {3'b0, dut_w}, {3'b0, W_T0});
      tick(); tick(); check("ld_T2", {3'b0, dut_w}, {3'b0, W_T2});
      tick(); tick(); tick(); check("ld_T5", {3'b0, dut_w}, {3'b0, M_ZLOW | M_MARIN});
      tick(); tick(); check("ld_T7", {3'b0, dut_w}, {3'b0, M_MDROUT | M_GRA | M_RIN});
      tick(); check("ld_next_T0", {3'b0, dut_w}, {3'b0, W_T0});

      // add
      IR = 32'h19A38000;
      tick(); tick();
      tick(); check("add_T3", {3'b0, dut_w}, {3'b0, M_GRB | M_ROUT | M_YIN});
      tick(); check("add_T4", {3'b0, dut_w}, {3'b0, M_GRC | M_ROUT | M_ADD | M_ZIN});
      tick(); check("add_T5", {3'b0, dut_w}, {3'b0, W_WB});
      tick(); check("add_next_T0", {3'b0, dut_w}, {3'b0, W_T0});

      // fetch stall of three cycles, then ld that times out in T6
      IR = 32'h00800085; mem_rdy = 1'b0;
      tick(); check("stall_T1_0", {3'b0, dut_w}, {3'b0, W_T1});
      for (int i = 0; i < 3; i++) begin
         tick(); check("stall_T1", {3'b0, dut_w}, {3'b0, W_T1});
      end
      mem_rdy = 1'b1;
      tick(); check("stall_T2", {3'b0, dut_w}, {3'b0, W_T2});
      tick(); tick(); tick();
      mem_rdy = 1'b0;
      tick();
      repeat (15) tick();
      check("to_still_T6", {3'b0, dut_w}, {3'b0, M_READ | M_MDRIN});
      check("to_no_err_yet", {31'b0, mem_err}, 32'h0);
      tick();
      check("to_halt_ctrl", {3'b0, dut_w}, 32'h0);
      check("to_halt_run", {31'b0, Run}, 32'h0);
      check("to_err", {31'b0, mem_err}, 32'h1);
      repeat (3) tick();
      check("halt_stays", {31'b0, Run}, 32'h0);

      clear = 1'b0;
      tick(); check("clr_err", {31'b0, mem_err}, 32'h0);

      // st with stop pulse in T4 ignored, stop at end edge halts
      clear = 1'b1; IR = 32'h10000000; mem_rdy = 1'b1;
      repeat (5) tick();
      check("st_T4", {3'b0, dut_w}, {3'b0, M_COUT | M_ADD | M_ZIN});
      stop = 1'b1;
      tick(); stop = 1'b0;
      check("st_T5_run", {31'b0, Run}, 32'h1);
      tick(); check("st_T6", {3'b0, dut_w}, {3'b0, M_GRA | M_ROUT | M_MDRIN});
      mem_rdy = 1'b0;
      tick(); check("st_T7", {3'b0, dut_w}, {3'b0, M_WRITE});
      tick(); check("st_T7_wait", {3'b0, dut_w}, {3'b0, M_WRITE});
      mem_rdy = 1'b1; stop = 1'b1;
      tick(); stop = 1'b0;
      check("st_stop_halt", {31'b0, Run}, 32'h0);

      // halt opcode
      clear = 1'b0; tick();
      clear = 1'b1; IR = 32'hD8000000;
      repeat (4) tick();
      check("hlt_T3_ctrl", {3'b0, dut_w}, 32'h0);
      check("hlt_T3_run", {31'b0, Run}, 32'h1);
      tick(); check("hlt_run", {31'b0, Run}, 32'h0);

      // asynchronous clear in the middle of T4
      clear = 1'b0; tick();
      clear = 1'b1; IR = 32'h00800085;
      repeat (5) tick();
      check("async_pre_T4", {3'b0, dut_w}, {3'b0, M_COUT | M_ADD | M_ZIN});
      #2 clear = 1'b0;
      #1 check("async_ctrl", {3'b0, dut_w}, 32'h0);
      check("async_run", {31'b0, Run}, 32'h0);
      model_advance();
      @(posedge clk); @(negedge clk); compare_all();
      clear = 1'b1;
      tick(); check("async_restart", {3'b0, dut_w}, {3'b0, W_T0});

      // ready arriving exactly on the timeout edge wins
      mem_rdy = 1'b0;
      tick();
      repeat (15) tick();
      mem_rdy = 1'b1;
      tick();
      check("edge_T2", {3'b0, dut_w}, {3'b0, W_T2});
      check("edge_no_err", {31'b0, mem_err}, 32'h0);

      // randomized instruction streams
      stall = 0;
      for (int i = 0; i < 4000; i++) begin
         clear = (m_mode == 2 || $urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         if (m_mode == 1 && m_q[0].t <= 3'd1) IR = pick_ir();
         if (stall > 0) begin
            mem_rdy = 1'b0; stall--;
         end else begin
            mem_rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) stall = $urandom_range(12, 20);
         end
         stop = ($urandom_range(0, 9) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
